// File: rtl/rtc_alarm.sv
// Alarm comparator for an epoch-seconds timer: one-shot or repeating alarm with
// a level interrupt and a saturating count of repeat matches missed while fired.
module rtc_alarm #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         cur_time,
    input  logic                alarm_we,
    input  logic [63:0]         alarm_time,
    input  logic                period_we,
    input  logic [PERIOD_W-1:0] period,
    input  logic                arm,
    input  logic                disarm,
    input  logic                ack,
    output logic                irq,
    output logic [1:0]          state,
    output logic [7:0]          missed
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FIRED = 2'b10
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic                  irq_r;
    logic [7:0]            missed_r;
    logic [7:0]            missed_nx_s;
    logic [63:0]           alarm_r;
    logic [63:0]           alarm_nx_s;
    logic [PERIOD_W-1:0]   period_r;
    logic                  period_nz_s;
    logic                  match_s;
    logic                  advance_s;

    // A write to the alarm register masks the compare for that cycle.
    assign match_s     = (cur_time >= alarm_r) && !alarm_we;
    assign period_nz_s = (period_r != {PERIOD_W{1'b0}});

    // Next-state, missed counter and alarm advance; disarm > arm > ack > match.
    always_comb begin
        state_nx_s  = state_r;
        missed_nx_s = missed_r;
        advance_s   = 1'b0;
        if (disarm) begin
            state_nx_s = ST_IDLE;
        end else if (arm) begin
            state_nx_s  = ST_ARMED;
            missed_nx_s = 8'd0;
        end else if (ack && (state_r == ST_FIRED)) begin
            state_nx_s = period_nz_s ? ST_ARMED : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_IDLE;
                end
                ST_ARMED: begin
                    if (match_s) begin
                        state_nx_s = ST_FIRED;
                        advance_s  = period_nz_s;
                    end else begin
                        state_nx_s = ST_ARMED;
                    end
                end
                ST_FIRED: begin
                    if (match_s && period_nz_s) begin
                        advance_s   = 1'b1;
                        missed_nx_s = (missed_r == 8'hFF) ? 8'hFF : (missed_r + 8'd1);
                    end else begin
                        advance_s = 1'b0;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end

        if (alarm_we) begin
            alarm_nx_s = alarm_time;
        end else if (advance_s) begin
            alarm_nx_s = alarm_r + 64'(period_r);
        end else begin
            alarm_nx_s = alarm_r;
        end
    end

    // State, interrupt and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            irq_r    <= 1'b0;
            missed_r <= 8'd0;
            alarm_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            period_r <= {PERIOD_W{1'b0}};
        end else begin
            state_r  <= state_nx_s;
            irq_r    <= (state_nx_s == ST_FIRED);
            missed_r <= missed_nx_s;
            alarm_r  <= alarm_nx_s;
            if (period_we) begin
                period_r <= period;
            end else begin
                period_r <= period_r;
            end
        end
    end

    assign irq    = irq_r;
    assign state  = state_r;
    assign missed = missed_r;

endmodule

// File: tb/tb_rtc_alarm.sv
// Scoreboard bench for rtc_alarm: a reference model pushes expected outputs per
// clock, which are popped and compared one cycle later; scenario constants too.
module tb_rtc_alarm;

    localparam int PW = 32;

    logic          clk;
    logic          rst;
    logic [63:0]   cur_time;
    logic          alarm_we;
    logic [63:0]   alarm_time;
    logic          period_we;
    logic [PW-1:0] period;
    logic          arm;
    logic          disarm;
    logic          ack;
    logic          irq;
    logic [1:0]    state;
    logic [7:0]    missed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       irq;
        logic [7:0] ms;
    } exp_t;
    exp_t sb[$];

    logic [1:0]    m_state;
    logic [7:0]    m_missed;
    logic [63:0]   m_alarm;
    logic [PW-1:0] m_period;

    rtc_alarm #(.PERIOD_W(PW)) dut (
        .clk(clk), .rst(rst), .cur_time(cur_time),
        .alarm_we(alarm_we), .alarm_time(alarm_time),
        .period_we(period_we), .period(period),
        .arm(arm), .disarm(disarm), .ack(ack),
        .irq(irq), .state(state), .missed(missed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 2'b00;
        m_missed = 8'd0;
        m_alarm  = 64'hFFFF_FFFF_FFFF_FFFF;
        m_period = '0;
    endtask

    // Reference behaviour for one rising edge, using the inputs now applied.
    task automatic model_edge(input string tag);
        logic       hit;
        logic       adv;
        logic [1:0] ns;
        logic [7:0] nm;
        exp_t       e;
        hit = (cur_time >= m_alarm) && !alarm_we;
        adv = 1'b0;
        ns  = m_state;
        nm  = m_missed;
        if (disarm) ns = 2'b00;
        else if (arm) begin ns = 2'b01; nm = 8'd0; end
        else if (ack && m_state == 2'b10) ns = (m_period != 0) ? 2'b01 : 2'b00;
        else if (hit && m_state == 2'b01) begin ns = 2'b10; adv = (m_period != 0); end
        else if (hit && m_state == 2'b10 && m_period != 0) begin
            adv = 1'b1;
            nm  = (m_missed == 8'd255) ? 8'd255 : m_missed + 8'd1;
        end
        if (alarm_we) m_alarm = alarm_time;
        else if (adv) m_alarm = m_alarm + {32'd0, m_period};
        if (period_we) m_period = period;
        m_state  = ns;
        m_missed = nm;
        e.tag = tag; e.st = ns; e.irq = (ns == 2'b10); e.ms = nm;
        sb.push_back(e);
    endtask

    task automatic cyc(input string tag);
        exp_t e;
        model_edge(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({e.tag, ".state"}, {62'd0, state}, {62'd0, e.st});
        check_eq({e.tag, ".irq"}, {63'd0, irq}, {63'd0, e.irq});
        check_eq({e.tag, ".missed"}, {56'd0, missed}, {56'd0, e.ms});
        alarm_we  = 1'b0;
        period_we = 1'b0;
        arm       = 1'b0;
        disarm    = 1'b0;
        ack       = 1'b0;
    endtask

    task automatic setup(input logic [63:0] at, input logic [PW-1:0] per);
        disarm = 1'b1; cur_time = 64'd0;
        alarm_we = 1'b1; alarm_time = at;
        period_we = 1'b1; period = per;
        cyc("setup");
        arm = 1'b1;
        cyc("arm");
    endtask

    initial begin
        rst = 1'b1; cur_time = 64'd0; alarm_we = 1'b0; alarm_time = 64'd0;
        period_we = 1'b0; period = '0; arm = 1'b0; disarm = 1'b0; ack = 1'b0;
        model_reset();
        #12;
        check_eq("rst.state", {62'd0, state}, 64'd0);
        check_eq("rst.irq", {63'd0, irq}, 64'd0);
        check_eq("rst.missed", {56'd0, missed}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // One-shot
        setup(64'd100, 32'd0);
        cur_time = 64'd98;  cyc("os98");
        cur_time = 64'd99;  cyc("os99");
        check_eq("os99.irq", {63'd0, irq}, 64'd0);
        cur_time = 64'd100; cyc("os100");
        check_eq("os100.irq", {63'd0, irq}, 64'd1);
        cur_time = 64'd101; cyc("os_nomore");
        ack = 1'b1; cyc("os_ack");
        check_eq("os_ack.state", {62'd0, state}, 64'd0);

        // Repeat
        setup(64'd10, 32'd5);
        cur_time = 64'd10; cyc("rp10");
        check_eq("rp10.state", {62'd0, state}, 64'd2);
        ack = 1'b1; cyc("rp_ack");
        check_eq("rp_ack.state", {62'd0, state}, 64'd1);
        cur_time = 64'd14; cyc("rp14");
        cur_time = 64'd15; cyc("rp15");
        check_eq("rp15.irq", {63'd0, irq}, 64'd1);
        ack = 1'b1; cur_time = 64'd19; cyc("rp_ack2");
        cur_time = 64'd20; cyc("rp20");

        // Missed counting
        setup(64'd50, 32'd1);
        for (int t = 50; t <= 53; t++) begin
            cur_time = 64'(t);
            cyc("ms_run");
        end
        check_eq("ms3.missed", {56'd0, missed}, 64'd3);
        check_eq("ms3.irq", {63'd0, irq}, 64'd1);
        arm = 1'b1; cyc("ms_arm");
        check_eq("ms_arm.missed", {56'd0, missed}, 64'd0);

        // Saturation, then disarm keeps the count
        setup(64'd10, 32'd1);
        cur_time = 64'h0000_0000_FFFF_0000;
        for (int i = 0; i < 260; i++) cyc("sat");
        check_eq("sat.missed", {56'd0, missed}, 64'd255);
        disarm = 1'b1; cyc("sat_disarm");
        check_eq("sat_disarm.missed", {56'd0, missed}, 64'd255);

        // Time jump and 64-bit wrap of the advance
        setup(64'd1000, 32'd0);
        cur_time = 64'd5000; cyc("jump");
        check_eq("jump.irq", {63'd0, irq}, 64'd1);
        setup(64'hFFFF_FFFF_FFFF_FFFE, 32'd4);
        cur_time = 64'hFFFF_FFFF_FFFF_FFFF; cyc("wrap_fire");
        ack = 1'b1; cur_time = 64'd1; cyc("wrap_ack");
        cyc("wrap1");
        cur_time = 64'd2; cyc("wrap2");
        check_eq("wrap2.state", {62'd0, state}, 64'd2);

        // Priority: all requests in FIRED
        disarm = 1'b1; arm = 1'b1; ack = 1'b1; cyc("prio_all");
        check_eq("prio_all.state", {62'd0, state}, 64'd0);
        // alarm_we masks a same-cycle match
        setup(64'd1000, 32'd0);
        cur_time = 64'd500; alarm_we = 1'b1; alarm_time = 64'd400; cyc("we_mask");
        check_eq("we_mask.state", {62'd0, state}, 64'd1);
        cyc("we_next");
        check_eq("we_next.state", {62'd0, state}, 64'd2);
        // period_we during an advance uses the old period
        setup(64'd10, 32'd5);
        cur_time = 64'd10; period_we = 1'b1; period = 32'd100; cyc("pw_adv");
        ack = 1'b1; cyc("pw_ack");
        cur_time = 64'd15; cyc("pw15");
        check_eq("pw15.state", {62'd0, state}, 64'd2);

        // Asynchronous reset while FIRED with missed > 0
        setup(64'd20, 32'd1);
        cur_time = 64'd100; cyc("rf_fire");
        cyc("rf_miss");
        check_eq("rf_miss.missed", {56'd0, missed}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst.irq", {63'd0, irq}, 64'd0);
        check_eq("arst.state", {62'd0, state}, 64'd0);
        check_eq("arst.missed", {56'd0, missed}, 64'd0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        // Alarm reset value is all ones
        arm = 1'b1; cur_time = 64'hFFFF_FFFF_FFFF_FFFE; cyc("post_arm");
        cyc("post_nofire");
        check_eq("post_nofire.state", {62'd0, state}, 64'd1);
        cur_time = 64'hFFFF_FFFF_FFFF_FFFF; cyc("post_fire");
        check_eq("post_fire.irq", {63'd0, irq}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
